// File: rtl/serial_rx_framer_pkg.sv
// Shared definitions for the serial receive framer: state encoding, default
// frame parameters and the bit-count width derivation.
package serial_rx_framer_pkg;

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_HUNT = ST_HUNT,
      S_RECV = ST_RECV,
      S_DONE = ST_DONE
   } rx_state_e;

   localparam int unsigned DEF_NDATA     = 128;
   localparam int unsigned DEF_OSR       = 4;
   localparam int unsigned DEF_SYNC_LEN  = 8;
   localparam logic [7:0]  DEF_SYNC_WORD = 8'hD5;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_rx_framer_bit_sampler.sv
// Bit timing recovery: 2-FF synchronizer, edge detect, phase counter and sample
// strobe. Define SERIAL_RX_MAJORITY_EN for a 3-tap majority vote around mid-bit.
module serial_rx_framer_bit_sampler
   import serial_rx_framer_pkg::*;
#(
   parameter int unsigned OSR = DEF_OSR
) (
   input  logic clk,
   input  logic rst,
   input  logic rx_i,
   output logic smp_vld_o,
   output logic smp_bit_o
);

   localparam int unsigned PH_W = $clog2(OSR);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2 - 1);

   logic            rx_m_q, rx_s_q, rx_p_q;
   logic [PH_W-1:0] ph_q, ph_d;
   logic            rx_edge;

   assign rx_edge = rx_s_q ^ rx_p_q;

   // Any line transition realigns the bit phase, so the sample lands two clocks after it.
   always_comb begin
      ph_d = ph_q + 1'b1;
      if (rx_edge || ph_q == PH_LAST) ph_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m_q <= 1'b0;
         rx_s_q <= 1'b0;
         rx_p_q <= 1'b0;
         ph_q   <= '0;
      end else begin
         rx_m_q <= rx_i;
         rx_s_q <= rx_m_q;
         rx_p_q <= rx_s_q;
         ph_q   <= ph_d;
      end
   end

`ifdef SERIAL_RX_MAJORITY_EN
   localparam logic [PH_W-1:0] PH_PRE  = PH_W'(OSR / 2 - 2);
   localparam logic [PH_W-1:0] PH_POST = PH_W'(OSR / 2);

   logic tap0_q, tap1_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap0_q <= 1'b0;
         tap1_q <= 1'b0;
      end else begin
         if (ph_q == PH_PRE) tap0_q <= rx_s_q;
         if (ph_q == PH_MID) tap1_q <= rx_s_q;
      end
   end

   assign smp_vld_o = (ph_q == PH_POST) && !rx_edge;
   assign smp_bit_o = maj3(tap0_q, tap1_q, rx_s_q);
`else
   assign smp_vld_o = (ph_q == PH_MID) && !rx_edge;
   assign smp_bit_o = rx_s_q;
`endif

endmodule

// File: rtl/serial_rx_framer.sv
// Receive-path front end: hunts for the sync word, then strobes out NDATA
// payload bits with a running count. Optional macro: SERIAL_RX_MAJORITY_EN.
module serial_rx_framer
   import serial_rx_framer_pkg::*;
#(
   parameter  int unsigned          NDATA     = DEF_NDATA,
   parameter  int unsigned          OSR       = DEF_OSR,
   parameter  int unsigned          SYNC_LEN  = DEF_SYNC_LEN,
   parameter  logic [SYNC_LEN-1:0]  SYNC_WORD = DEF_SYNC_WORD,
   localparam int unsigned          NDATA_LOG = cnt_width(NDATA)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic                 dout,
   output logic                 ena,
   output logic [NDATA_LOG-1:0] cntout,
   output logic                 frame_done,
   output logic                 busy
);

   localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);

   rx_state_e             state_q;
   logic [SYNC_LEN-1:0]   sh_q, sh_d;
   logic [NDATA_LOG-1:0]  cnt_q;
   logic                  ena_q, dout_q, fd_q, busy_q;
   logic                  smp_vld, smp_bit;

   serial_rx_framer_bit_sampler #(
      .OSR (OSR)
   ) u_sampler (
      .clk       (clk),
      .rst       (rst),
      .rx_i      (rx_in),
      .smp_vld_o (smp_vld),
      .smp_bit_o (smp_bit)
   );

   assign sh_d = {sh_q[SYNC_LEN-2:0], smp_bit};

   // ena is a pure strobe with no back-pressure: the consumer must take dout
   // and cntout in every cycle ena is high; both hold their values otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_HUNT;
         sh_q    <= '0;
         cnt_q   <= '0;
         ena_q   <= 1'b0;
         dout_q  <= 1'b0;
         fd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ena_q <= 1'b0;
         fd_q  <= 1'b0;
         case (state_q)
            S_HUNT: begin
               if (smp_vld) begin
                  sh_q <= sh_d;
                  if (sh_d == SYNC_WORD) begin
                     state_q <= S_RECV;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (smp_vld) begin
                  ena_q  <= 1'b1;
                  dout_q <= smp_bit;
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               fd_q    <= 1'b1;
               cnt_q   <= '0;
               sh_q    <= '0;
               busy_q  <= 1'b0;
               state_q <= S_HUNT;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_HUNT;
            end
         endcase
      end
   end

   assign ena        = ena_q;
   assign dout       = dout_q;
   assign cntout     = cnt_q;
   assign frame_done = fd_q;
   assign busy       = busy_q;

endmodule
